// File: rtl/coef_ram_loader.sv
// Coefficient RAM writer: parses framed load packets from a byte stream and
// writes each payload byte into the 128x8 coefficient RAM.
//
// state | meaning
// IDLE  | waiting for HEADER, other bytes ignored
// ADDR  | expecting start address (bit7 must be 0)
// LEN   | expecting payload length (1..128)
// DATA  | writing payload bytes, address wraps 127->0
// CSUM  | expecting checksum byte, frame accepted if the running sum closes to 0
module coef_ram_loader #(
  parameter logic [7:0] HEADER  = 8'hA5,
  parameter int         TIMEOUT = 2000000,
  parameter int         TO_BITS = 24
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [6:0] RAM_coefs_wraddr,
  output logic [7:0] RAM_coefs_datain,
  output logic       RAM_coefs_we,
  output logic       busy,
  output logic       frame_done,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic [7:0] frame_count
);

  localparam logic [TO_BITS-1:0] TO_LAST = TO_BITS'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, ADDR, LEN, DATA, CSUM} state_t;

  state_t             state, state_n;
  logic [6:0]         addr, addr_n;
  logic [7:0]         remaining, remaining_n;
  logic [7:0]         sum, sum_n;
  logic [TO_BITS-1:0] to_cnt, to_cnt_n;
  logic [6:0]         wraddr_n;
  logic [7:0]         datain_n;
  logic               we_n, done_n, err_n;
  logic [1:0]         code_n;
  logic [7:0]         count_n;
  logic [7:0]         sum_plus;
  logic               expired;

  assign sum_plus = sum + rx_data;
  // an arriving byte always beats a simultaneous expiry
  assign expired  = (state != IDLE) && !rx_valid && (to_cnt == TO_LAST);
  assign busy     = (state != IDLE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      addr             <= '0;
      remaining        <= '0;
      sum              <= '0;
      to_cnt           <= '0;
      RAM_coefs_wraddr <= '0;
      RAM_coefs_datain <= '0;
      RAM_coefs_we     <= 1'b0;
      frame_done       <= 1'b0;
      frame_err        <= 1'b0;
      err_code         <= 2'd0;
      frame_count      <= '0;
    end else begin
      state            <= state_n;
      addr             <= addr_n;
      remaining        <= remaining_n;
      sum              <= sum_n;
      to_cnt           <= to_cnt_n;
      RAM_coefs_wraddr <= wraddr_n;
      RAM_coefs_datain <= datain_n;
      RAM_coefs_we     <= we_n;
      frame_done       <= done_n;
      frame_err        <= err_n;
      err_code         <= code_n;
      frame_count      <= count_n;
    end
  end

  always_comb begin
    state_n     = state;
    addr_n      = addr;
    remaining_n = remaining;
    sum_n       = sum;
    wraddr_n    = RAM_coefs_wraddr;
    datain_n    = RAM_coefs_datain;
    we_n        = 1'b0;
    done_n      = 1'b0;
    err_n       = 1'b0;
    code_n      = err_code;
    count_n     = frame_count;

    if (rx_valid) begin
      unique case (state)
        IDLE: if (rx_data == HEADER) state_n = ADDR;
        ADDR: begin
          if (rx_data[7]) begin
            err_n   = 1'b1;
            code_n  = 2'd1;
            state_n = IDLE;
          end else begin
            addr_n  = rx_data[6:0];
            sum_n   = rx_data;
            state_n = LEN;
          end
        end
        LEN: begin
          if (rx_data == 8'd0 || rx_data > 8'd128) begin
            err_n   = 1'b1;
            code_n  = 2'd1;
            state_n = IDLE;
          end else begin
            remaining_n = rx_data;
            sum_n       = sum_plus;
            state_n     = DATA;
          end
        end
        DATA: begin
          we_n        = 1'b1;
          wraddr_n    = addr;
          datain_n    = rx_data;
          addr_n      = addr + 7'd1;
          remaining_n = remaining - 8'd1;
          sum_n       = sum_plus;
          if (remaining == 8'd1) state_n = CSUM;
        end
        CSUM: begin
          if (sum_plus == 8'd0) begin
            done_n  = 1'b1;
            code_n  = 2'd0;
            count_n = frame_count + 8'd1;
          end else begin
            err_n  = 1'b1;
            code_n = 2'd3;
          end
          state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end else if (expired) begin
      err_n   = 1'b1;
      code_n  = 2'd2;
      state_n = IDLE;
    end

    if (state_n == IDLE || rx_valid) to_cnt_n = '0;
    else                             to_cnt_n = to_cnt + TO_BITS'(1);
  end

endmodule

// File: tb/tb_coef_ram_loader.sv
// Bench for coef_ram_loader: byte-stream schedules are parsed by a frame-level
// reference model into per-edge expectations compared against the DUT.
module tb_coef_ram_loader;
  localparam int         TIMEOUT = 100;
  localparam logic [7:0] HEADER  = 8'hA5;
  localparam int         MAXT    = 10000;
  localparam int         MAXB    = 4000;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] rx_data = 8'd0;
  logic       rx_valid = 1'b0;
  logic [6:0] RAM_coefs_wraddr;
  logic [7:0] RAM_coefs_datain;
  logic       RAM_coefs_we, busy, frame_done, frame_err;
  logic [1:0] err_code;
  logic [7:0] frame_count;

  coef_ram_loader #(.HEADER(HEADER), .TIMEOUT(TIMEOUT), .TO_BITS(8)) dut (
    .clock(clock), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .RAM_coefs_wraddr(RAM_coefs_wraddr), .RAM_coefs_datain(RAM_coefs_datain),
    .RAM_coefs_we(RAM_coefs_we), .busy(busy), .frame_done(frame_done),
    .frame_err(frame_err), .err_code(err_code), .frame_count(frame_count));

  always #5 clock = ~clock;

  int n_cmp = 0, n_bad = 0;

  // byte stream: value and the edge at which it is strobed
  logic [7:0] bval[MAXB];
  int         bt[MAXB];
  int         nb;
  int         sched[MAXT];
  int         t_end;

  // expected state visible just after each edge
  logic       e_we[MAXT], e_done[MAXT], e_err[MAXT], e_busy[MAXT];
  logic [6:0] e_wa[MAXT];
  logic [7:0] e_wd[MAXT];
  logic [1:0] e_code[MAXT];
  logic [7:0] e_cnt[MAXT];
  int         ev[MAXT];

  // observations of the DUT for literal checks
  logic [6:0] wl_a[$];
  logic [7:0] wl_d[$];
  int         n_done_seen, n_err_seen, to_edge;

  task automatic check(input string name, input int e, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @edge %0d: got 0x%0h want 0x%0h", name, e, act, exp);
    end
  endtask

  task automatic clear_sched();
    for (int t = 0; t < MAXT; t++) sched[t] = -1;
    nb = 0;
  endtask

  task automatic push(input logic [7:0] b, input int gap);
    int t;
    t = (nb == 0) ? gap : bt[nb-1] + gap;
    if (t >= MAXT - TIMEOUT - 10 || nb >= MAXB) return;
    bval[nb] = b;
    bt[nb]   = t;
    sched[t] = nb;
    nb++;
  endtask

  function automatic int rgap();
    int r;
    r = $urandom_range(0, 99);
    if (r < 85) return 1;
    if (r < 95) return $urandom_range(2, 5);
    return $urandom_range(TIMEOUT - 5, TIMEOUT + 5);
  endfunction

  // Walks the stream frame by frame using byte positions within each frame.
  task automatic build_model();
    int i, s, pos, j, len, endt, fin;
    logic [6:0] a;
    logic [7:0] sum, b, cnt;
    logic [1:0] code;
    for (int t = 0; t < MAXT; t++) begin
      e_we[t] = 0; e_done[t] = 0; e_err[t] = 0; e_busy[t] = 0;
      e_wa[t] = 0; e_wd[t] = 0; ev[t] = -1;
    end
    i = 0;
    while (i < nb) begin
      if (bval[i] !== HEADER) begin i++; continue; end
      s = i; pos = 1; fin = 0; len = 0; a = 0; sum = 0; endt = bt[s];
      while (fin == 0) begin
        j = s + pos;
        if (j >= nb || bt[j] - bt[j-1] > TIMEOUT) begin
          endt = bt[j-1] + TIMEOUT;
          e_err[endt] = 1; ev[endt] = 2; fin = 1; i = j;
        end else begin
          b = bval[j]; endt = bt[j];
          if (pos == 1) begin
            if (b[7]) begin e_err[endt] = 1; ev[endt] = 1; fin = 1; end
            else begin a = b[6:0]; sum = b; end
          end else if (pos == 2) begin
            if (b == 0 || b > 128) begin e_err[endt] = 1; ev[endt] = 1; fin = 1; end
            else begin len = int'(b); sum = sum + b; end
          end else if (pos <= len + 2) begin
            e_we[endt] = 1;
            e_wa[endt] = 7'((int'(a) + pos - 3) % 128);
            e_wd[endt] = b;
            sum = sum + b;
          end else begin
            if (8'(sum + b) == 8'd0) begin e_done[endt] = 1; ev[endt] = 0; end
            else begin e_err[endt] = 1; ev[endt] = 3; end
            fin = 1;
          end
          if (fin != 0) i = j + 1;
          pos++;
        end
      end
      for (int t = bt[s]; t < endt; t++) e_busy[t] = 1;
    end
    code = 0; cnt = 0;
    for (int t = 0; t < MAXT; t++) begin
      if (ev[t] >= 0) code = 2'(ev[t]);
      if (ev[t] == 0) cnt = cnt + 8'd1;
      e_code[t] = code;
      e_cnt[t]  = cnt;
    end
  endtask

  task automatic run_phase(input string tag);
    reset = 1'b0; rx_valid = 1'b0; rx_data = 8'd0;
    repeat (2) @(posedge clock);
    #1;
    check({tag, "_reset_outs"}, 0,
          32'({RAM_coefs_wraddr, RAM_coefs_datain, RAM_coefs_we, busy,
               frame_done, frame_err, err_code, frame_count}), 32'd0);
    @(posedge clock);
    #1 reset = 1'b1;
    for (int e = 1; e <= t_end; e++) begin
      if (sched[e] >= 0) begin rx_valid = 1'b1; rx_data = bval[sched[e]]; end
      else begin rx_valid = 1'b0; rx_data = 8'($urandom); end
      @(posedge clock);
      #1;
      check({tag, "_we"},    e, 32'(RAM_coefs_we), 32'(e_we[e]));
      check({tag, "_busy"},  e, 32'(busy),         32'(e_busy[e]));
      check({tag, "_done"},  e, 32'(frame_done),   32'(e_done[e]));
      check({tag, "_err"},   e, 32'(frame_err),    32'(e_err[e]));
      check({tag, "_code"},  e, 32'(err_code),     32'(e_code[e]));
      check({tag, "_count"}, e, 32'(frame_count),  32'(e_cnt[e]));
      if (e_we[e]) begin
        check({tag, "_wraddr"}, e, 32'(RAM_coefs_wraddr), 32'(e_wa[e]));
        check({tag, "_wdata"},  e, 32'(RAM_coefs_datain), 32'(e_wd[e]));
      end
      if (RAM_coefs_we) begin wl_a.push_back(RAM_coefs_wraddr); wl_d.push_back(RAM_coefs_datain); end
      if (frame_done) n_done_seen++;
      if (frame_err) n_err_seen++;
      if (frame_err && err_code == 2'd2) to_edge = e;
    end
    rx_valid = 1'b0;
  endtask

  initial begin
    int to_idx, r, r2, len;
    logic [7:0] a, l, s, d;

    // directed frames
    clear_sched();
    push(8'h00, 3); push(8'hFF, 1);
    push(HEADER, 2); push(8'h10, 1); push(8'h03, 1); push(8'h11, 1); push(8'h22, 1); push(8'h33, 1); push(8'h87, 1);
    push(HEADER, 3); push(8'h7E, 1); push(8'h04, 2); push(8'h01, 1); push(8'h02, 1); push(8'h03, 2); push(8'h04, 1); push(8'h74, 1);
    push(HEADER, 2); push(8'h10, 1); push(8'h03, 1); push(8'h11, 1); push(8'h22, 1); push(8'h33, 1); push(8'h00, 1);
    push(HEADER, 2); push(8'h80, 1);
    push(HEADER, 2); push(8'h10, 1); push(8'h00, 1);
    push(HEADER, 2); push(8'h10, 1); push(8'h81, 1);
    push(HEADER, 2); push(8'h10, 1); to_idx = nb - 1;
    push(HEADER, 150); push(8'h10, 1); push(8'h01, TIMEOUT); push(8'h55, 1); push(8'h9A, 1);
    t_end = bt[nb-1] + TIMEOUT + 5;
    build_model();
    check("model_final_count", t_end, 32'(e_cnt[t_end]), 32'd3);
    check("model_final_code",  t_end, 32'(e_code[t_end]), 32'd0);
    wl_a.delete(); wl_d.delete(); n_done_seen = 0; n_err_seen = 0; to_edge = -1;
    run_phase("dir");
    check("dir_n_writes", 0, 32'(wl_a.size()), 32'd11);
    if (wl_a.size() >= 7) begin
      check("dir_w0", 0, 32'({wl_a[0], wl_d[0]}), 32'({7'h10, 8'h11}));
      check("dir_w1", 0, 32'({wl_a[1], wl_d[1]}), 32'({7'h11, 8'h22}));
      check("dir_w2", 0, 32'({wl_a[2], wl_d[2]}), 32'({7'h12, 8'h33}));
      check("dir_wrap_addrs", 0, 32'({wl_a[3], wl_a[4], wl_a[5], wl_a[6]}),
            32'({7'h7E, 7'h7F, 7'h00, 7'h01}));
    end
    check("dir_n_done", 0, 32'(n_done_seen), 32'd3);
    check("dir_n_err",  0, 32'(n_err_seen),  32'd5);
    check("dir_timeout_edge", 0, 32'(to_edge), 32'(bt[to_idx] + 100));
    check("dir_final_count", t_end, 32'(frame_count), 32'd3);

    // randomized frames
    clear_sched();
    while (nb < MAXB - 200 && (nb == 0 || bt[nb-1] < MAXT - 2500)) begin
      r = $urandom_range(0, 99);
      if (r < 8) push(8'($urandom), rgap());
      else begin
        a = ($urandom_range(0, 19) == 0) ? 8'($urandom_range(128, 255)) : 8'($urandom_range(0, 127));
        r2 = $urandom_range(0, 99);
        l = (r2 < 5) ? 8'd0 : (r2 < 10) ? 8'($urandom_range(129, 255)) :
            (r2 < 15) ? 8'd128 : 8'($urandom_range(1, 6));
        push(HEADER, rgap()); push(a, rgap()); push(l, rgap());
        s = a + l;
        len = (l == 0 || l > 128) ? $urandom_range(0, 2) : int'(l);
        for (int k = 0; k < len; k++) begin
          d = 8'($urandom); push(d, rgap()); s = s + d;
        end
        push(($urandom_range(0, 4) == 0) ? 8'($urandom) : (8'h00 - s), rgap());
      end
    end
    t_end = bt[nb-1] + TIMEOUT + 5;
    build_model();
    run_phase("rnd");

    // reset in the middle of a payload
    clear_sched();
    push(HEADER, 3); push(8'h10, 1); push(8'h03, 1); push(8'h11, 1);
    t_end = bt[nb-1];
    build_model();
    run_phase("rstA");
    #2 reset = 1'b0;
    #1;
    check("rst_async_outs", t_end,
          32'({RAM_coefs_wraddr, RAM_coefs_datain, RAM_coefs_we, busy,
               frame_done, frame_err, err_code, frame_count}), 32'd0);
    clear_sched();
    push(8'h22, 3); push(8'h33, 1);
    push(HEADER, 2); push(8'h10, 1); push(8'h03, 1); push(8'h11, 1); push(8'h22, 1); push(8'h33, 1); push(8'h87, 1);
    t_end = bt[nb-1] + 5;
    build_model();
    run_phase("rstB");
    check("rstB_final_count", t_end, 32'(frame_count), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
